// File: rtl/ask_uart_rx_demod.sv
// ASK envelope slicer plus UART (8N1) frame recovery timed in input samples, with a 1-deep AXI-Stream byte output.
// Optional build macro ASK_RX_MAJORITY_EN enables a 3-sample majority vote on the sliced level.
module ask_uart_rx_demod #(
  parameter int WIDTH           = 16,
  parameter int SAMPLES_PER_BIT = 40,
  parameter int CNT_W           = $clog2(SAMPLES_PER_BIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] threshold,
  output logic [7:0]       o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             bit_level,
  output logic             busy,
  output logic             framing_err,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_HALF_M1 = CNT_W'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LP_FULL_M1 = CNT_W'(SAMPLES_PER_BIT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_shreg;
  logic             r_level;

  logic             w_strobe;
  logic signed [WIDTH:0] w_diff;
  logic [WIDTH:0]   w_neg;
  logic [WIDTH:0]   w_mag;
  logic             w_raw;
  logic             w_level_now;

  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_bitidx_clr;
  logic             w_shift;
  logic             w_byte_done;
  logic             w_frame_err;

  assign w_strobe = i_tvalid & enable;

  // Slicer: one extra bit of headroom so the difference and its magnitude never wrap.
  assign w_diff = $signed({i_tdata[WIDTH-1], i_tdata}) - $signed({offset[WIDTH-1], offset});
  assign w_neg  = ~w_diff + {{WIDTH{1'b0}}, 1'b1};
  assign w_mag  = w_diff[WIDTH] ? w_neg : $unsigned(w_diff);
  assign w_raw  = (w_mag >= {1'b0, threshold});

`ifdef ASK_RX_MAJORITY_EN
  logic [2:0] r_hist;
  logic [2:0] w_hist_next;

  assign w_hist_next = {r_hist[1:0], w_raw};
  assign w_level_now = (w_hist_next[0] & w_hist_next[1]) |
                       (w_hist_next[0] & w_hist_next[2]) |
                       (w_hist_next[1] & w_hist_next[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 3'b111;
    end else if (clear) begin
      r_hist <= 3'b111;
    end else if (w_strobe) begin
      r_hist <= w_hist_next;
    end
  end
`else
  assign w_level_now = w_raw;
`endif

  // r_level is the level of the previous sample; w_level_now is the level of the sample on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b1;
    end else if (clear) begin
      r_level <= 1'b1;
    end else if (w_strobe) begin
      r_level <= w_level_now;
    end
  end

  assign bit_level = r_level;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = S_IDLE;
    end else if (i_tvalid) begin
      case (r_state)
        S_IDLE: begin
          if (r_level && !w_level_now) w_state_next = S_START;
        end
        S_START: begin
          if (r_cnt == LP_HALF_M1) w_state_next = w_level_now ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if ((r_cnt == LP_FULL_M1) && (r_bitidx == 3'd7)) w_state_next = S_STOP;
        end
        S_STOP: begin
          if (r_cnt == LP_FULL_M1) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_bitidx_clr = 1'b0;
    w_shift      = 1'b0;
    w_byte_done  = 1'b0;
    w_frame_err  = 1'b0;
    if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          w_cnt_clr = 1'b1;
        end
        S_START: begin
          if (r_cnt == LP_HALF_M1) begin
            w_cnt_clr    = 1'b1;
            w_bitidx_clr = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LP_FULL_M1) begin
            w_cnt_clr = 1'b1;
            w_shift   = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == LP_FULL_M1) begin
            w_cnt_clr   = 1'b1;
            w_byte_done = w_level_now;
            w_frame_err = ~w_level_now;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        default: w_cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shreg  <= '0;
    end else if (clear || !enable) begin
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shreg  <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_bitidx_clr) begin
        r_bitidx <= '0;
      end else if (w_shift) begin
        r_bitidx <= r_bitidx + 1'b1;
      end
      // LSB arrives first, so each new bit enters at the top and moves down.
      if (w_shift) r_shreg <= {w_level_now, r_shreg[7:1]};
    end
  end

  // o_tvalid/o_tready: a byte moves when both are high on a clock edge; o_tdata holds while o_tvalid & !o_tready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tdata     <= 8'h00;
      o_tvalid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear) begin
      o_tdata     <= 8'h00;
      o_tvalid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= w_frame_err;
      overrun     <= 1'b0;
      if (w_byte_done) begin
        if (!o_tvalid || o_tready) begin
          o_tdata  <= r_shreg;
          o_tvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (o_tvalid && o_tready) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ask_uart_rx_demod.sv
// Directed bench for ask_uart_rx_demod: table of frames plus hand-written error, overrun, reset and glitch sequences.
module tb_ask_uart_rx_demod;
  localparam int W   = 16;
  localparam int SPB = 4;
`ifdef ASK_RX_MAJORITY_EN
  localparam int         STOP_IDX    = 3;
  localparam logic [7:0] GL_EXP_BYTE = 8'hFF;
  localparam logic       GL_EXP_BL   = 1'b1;
`else
  localparam int         STOP_IDX    = 2;
  localparam logic [7:0] GL_EXP_BYTE = 8'hFE;
  localparam logic       GL_EXP_BL   = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         enable;
  logic [W-1:0] i_tdata;
  logic         i_tvalid;
  logic [W-1:0] offset;
  logic [W-1:0] threshold;
  logic [7:0]   o_tdata;
  logic         o_tvalid;
  logic         o_tready;
  logic         bit_level;
  logic         busy;
  logic         framing_err;
  logic         overrun;

  ask_uart_rx_demod #(
    .WIDTH(W),
    .SAMPLES_PER_BIT(SPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .offset(offset), .threshold(threshold),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .bit_level(bit_level), .busy(busy), .framing_err(framing_err), .overrun(overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  logic       cap_pre_v, cap_v, cap_bl;
  logic [7:0] cap_d;
  logic       g_bl0, g_bl1;

  // monitor: handshakes and pulses sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_tvalid && o_tready) rx_q.push_back(o_tdata);
      if (framing_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one sample per 3 clocks; the strobe edge is the second posedge
  task automatic send_sample(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    cap_pre_v = o_tvalid;
    i_tdata   = v;
    i_tvalid  = 1'b1;
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    cap_v    = o_tvalid;
    cap_d    = o_tdata;
    cap_bl   = bit_level;
    @(posedge clk);
  endtask

  task automatic send_idle(input int n, input logic neg);
    for (int i = 0; i < n; i++) send_sample(neg ? -16'sd1000 : 16'sd1000);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_ok, input logic neg,
                            input int glitch_at, input int nsamp, input logic lat_chk);
    int   b;
    logic lvl;
    logic [W-1:0] v;
    for (int n = 0; n < nsamp; n++) begin
      b = n / SPB;
      if (b == 0)      lvl = 1'b0;
      else if (b <= 8) lvl = data[b-1];
      else             lvl = stop_ok;
      v = lvl ? (neg ? -16'sd1000 : 16'sd1000) : 16'sd0;
      if (n == glitch_at) v = 16'sd0;
      send_sample(v);
      if (lat_chk && n == 9 * SPB + STOP_IDX) begin
        check("lat_pre_valid", cap_pre_v, 0);
        check("lat_valid", cap_v, 1);
        check("lat_data", cap_d, data);
      end
      if (n == glitch_at) g_bl0 = cap_bl;
      if (n == glitch_at + 1) g_bl1 = cap_bl;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       neg;
    int         idle_pre;
    logic       exp_beat;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int f0, o0;
    vecs[0] = '{8'h6E, 1'b1, 1'b0, 8, 1'b1, 8'h6E, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 4, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{8'd110, 1'b1, 1'b0, 4, 1'b1, 8'd110, 1'b0};
    vecs[3] = '{8'h04, 1'b1, 1'b0, 0, 1'b1, 8'h04, 1'b0};
    vecs[4] = '{8'h34, 1'b1, 1'b0, 0, 1'b1, 8'h34, 1'b0};
    vecs[5] = '{8'h12, 1'b1, 1'b0, 0, 1'b1, 8'h12, 1'b0};
    vecs[6] = '{8'd111, 1'b1, 1'b0, 0, 1'b1, 8'd111, 1'b0};
    vecs[7] = '{8'h55, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h0F, 1'b1, 1'b0, 8, 1'b1, 8'h0F, 1'b0};

    rst_n     = 1'b0;
    clear     = 1'b0;
    enable    = 1'b1;
    i_tdata   = 16'sd1000;
    i_tvalid  = 1'b0;
    offset    = '0;
    threshold = 16'd500;
    o_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdata", o_tdata, 0);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_bit_level", bit_level, 1);
    check("rst_busy", busy, 0);
    check("rst_ferr", framing_err, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table: single, negative envelope, back-to-back command, framing error, recovery
    for (int i = 0; i < 9; i++) begin
      offset = vecs[i].neg ? -16'sd20 : 16'sd0;
      send_idle(vecs[i].idle_pre, vecs[i].neg);
      if (vecs[i].exp_beat) exp_q.push_back(vecs[i].exp_data);
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].neg, -1, 10 * SPB, vecs[i].exp_beat);
      check("vec_beats", rx_q.size(), vecs[i].exp_beat);
      if (rx_q.size() > 0 && exp_q.size() > 0) check("vec_data", rx_q[0], exp_q[0]);
      rx_q.delete();
      exp_q.delete();
      check("vec_ferr", ferr_cnt - f0, vecs[i].exp_ferr);
      check("vec_overrun", ovr_cnt - o0, 0);
    end
    offset = '0;

    // 2-sample start glitch
    send_idle(4, 1'b0);
    send_sample(16'sd0);
    send_sample(16'sd0);
    #1;
    check("glitch_busy_hi", busy, 1);
    send_idle(8, 1'b0);
    #1;
    check("glitch_busy_lo", busy, 0);
    check("glitch_no_beat", rx_q.size(), 0);

    // overrun
    o_tready = 1'b0;
    o0 = ovr_cnt;
    send_idle(4, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, -1, 10 * SPB, 1'b0);
    send_idle(4, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, -1, 10 * SPB, 1'b0);
    #1;
    check("ovr_valid", o_tvalid, 1);
    check("ovr_hold_data", o_tdata, 8'h11);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_no_beat", rx_q.size(), 0);
    @(posedge clk);
    #1;
    o_tready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_drain_valid", o_tvalid, 0);
    check("ovr_drain_beats", rx_q.size(), 1);
    if (rx_q.size() > 0) check("ovr_drain_data", rx_q[0], 8'h11);
    rx_q.delete();

    // async reset in the middle of bit 3, with a byte still held
    o_tready = 1'b0;
    send_idle(4, 1'b0);
    send_frame(8'h99, 1'b1, 1'b0, -1, 10 * SPB, 1'b0);
    send_idle(4, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, -1, 4 * SPB + 2, 1'b0);
    #1;
    check("mid_valid_held", o_tvalid, 1);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", o_tvalid, 0);
    check("arst_tdata", o_tdata, 0);
    check("arst_bit_level", bit_level, 1);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    o_tready = 1'b1;
    send_idle(4, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, -1, 10 * SPB, 1'b1);
    check("post_rst_beats", rx_q.size(), 1);
    if (rx_q.size() > 0) check("post_rst_data", rx_q[0], 8'hC3);
    rx_q.delete();

    // single zero sample at the sampling point of data bit 0
    send_idle(4, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 2 * SPB - 2, 10 * SPB, 1'b0);
    check("gl_bit_level", g_bl0, GL_EXP_BL);
    check("gl_bit_level_after", g_bl1, 1);
    check("gl_beats", rx_q.size(), 1);
    if (rx_q.size() > 0) check("gl_data", rx_q[0], GL_EXP_BYTE);
    rx_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
